// File: rtl/mem_byte_initiator.sv
// mem_byte_initiator: turns byte-burst commands into single-byte read/write
// accesses towards a memory responder that signals completion with M_DataRdy.
// Writes pull one byte per access from the write stream. Reads push each
// returned byte onto the read stream. An access that sees no completion
// within TIMEOUT cycles aborts the burst and raises a sticky error flag.
module mem_byte_initiator #(
   parameter int TIMEOUT = 255
) (
   input  logic       clock_i,
   input  logic       reset_i,
   // command channel
   input  logic       cmd_valid_i,
   output logic       cmd_ready_o,
   input  logic       cmd_write_i,
   input  logic [6:0] cmd_addr_i,
   input  logic [7:0] cmd_len_i,
   // write-data stream
   input  logic [7:0] wr_data_i,
   input  logic       wr_valid_i,
   output logic       wr_ready_o,
   // read-data stream
   output logic [7:0] rd_data_o,
   output logic       rd_valid_o,
   input  logic       rd_ready_i,
   // memory responder side
   output logic       Mout_oe_ram_o,
   output logic       Mout_we_ram_o,
   output logic [6:0] Mout_addr_ram_o,
   output logic [7:0] Mout_Wdata_ram_o,
   output logic [3:0] Mout_data_ram_size_o,
   input  logic [7:0] M_Rdata_ram_i,
   input  logic       M_DataRdy_i,
   // status
   output logic       busy_o,
   output logic       err_timeout_o
);

   // Wide enough to hold TIMEOUT. The counter never reaches TIMEOUT itself,
   // because the burst aborts on the cycle the count would get there.
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      WAIT_WDATA = 3'd1,
      ACCESS     = 3'd2,
      PUSH_RDATA = 3'd3,
      ABORT      = 3'd4
   } state_t;

   state_t          state_q;
   logic            write_q;
   logic [6:0]      addr_q;
   logic [7:0]      rem_q;
   logic [CW-1:0]   cnt_q;
   logic            cmd_ready_q;
   logic            wr_ready_q;
   logic            rd_valid_q;
   logic [7:0]      rd_data_q;
   logic            oe_q;
   logic            we_q;
   logic [6:0]      maddr_q;
   logic [7:0]      mwdata_q;
   logic [3:0]      msize_q;
   logic            busy_q;
   logic            err_q;

   // Burst FSM. Every output is a flop that is updated together with the state
   // transition, so each output matches the state the FSM is in.
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q     <= IDLE;
         write_q     <= 1'b0;
         addr_q      <= 7'd0;
         rem_q       <= 8'd0;
         cnt_q       <= '0;
         cmd_ready_q <= 1'b1;
         wr_ready_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         rd_data_q   <= 8'd0;
         oe_q        <= 1'b0;
         we_q        <= 1'b0;
         maddr_q     <= 7'd0;
         mwdata_q    <= 8'd0;
         msize_q     <= 4'd0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // A zero-length command is accepted but does nothing.
               if (cmd_valid_i && cmd_ready_q && (cmd_len_i != 8'd0)) begin
                  write_q     <= cmd_write_i;
                  addr_q      <= cmd_addr_i;
                  rem_q       <= cmd_len_i;
                  cmd_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if (cmd_write_i) begin
                     state_q    <= WAIT_WDATA;
                     wr_ready_q <= 1'b1;
                  end else begin
                     state_q <= ACCESS;
                     oe_q    <= 1'b1;
                     maddr_q <= cmd_addr_i;
                     msize_q <= 4'd8;
                     cnt_q   <= '0;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end

            WAIT_WDATA: begin
               if (wr_valid_i) begin
                  state_q    <= ACCESS;
                  wr_ready_q <= 1'b0;
                  mwdata_q   <= wr_data_i;
                  we_q       <= 1'b1;
                  maddr_q    <= addr_q;
                  msize_q    <= 4'd8;
                  cnt_q      <= '0;
               end else begin
                  state_q <= WAIT_WDATA;
               end
            end

            ACCESS: begin
               if (M_DataRdy_i) begin
                  // Completion wins over a timeout that expires in the same cycle.
                  oe_q    <= 1'b0;
                  we_q    <= 1'b0;
                  msize_q <= 4'd0;
                  if (write_q) begin
                     rem_q  <= rem_q - 8'd1;
                     addr_q <= addr_q + 7'd1;
                     if (rem_q == 8'd1) begin
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        cmd_ready_q <= 1'b1;
                     end else begin
                        state_q    <= WAIT_WDATA;
                        wr_ready_q <= 1'b1;
                     end
                  end else begin
                     state_q    <= PUSH_RDATA;
                     rd_data_q  <= M_Rdata_ram_i;
                     rd_valid_q <= 1'b1;
                  end
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  state_q <= ABORT;
                  oe_q    <= 1'b0;
                  we_q    <= 1'b0;
                  msize_q <= 4'd0;
                  err_q   <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end

            PUSH_RDATA: begin
               if (rd_ready_i) begin
                  rd_valid_q <= 1'b0;
                  rem_q      <= rem_q - 8'd1;
                  addr_q     <= addr_q + 7'd1;
                  if (rem_q == 8'd1) begin
                     state_q     <= IDLE;
                     busy_q      <= 1'b0;
                     cmd_ready_q <= 1'b1;
                  end else begin
                     state_q <= ACCESS;
                     oe_q    <= 1'b1;
                     maddr_q <= addr_q + 7'd1;
                     msize_q <= 4'd8;
                     cnt_q   <= '0;
                  end
               end else begin
                  state_q <= PUSH_RDATA;
               end
            end

            ABORT: begin
               // Bytes still outstanding in the aborted burst are dropped.
               state_q     <= IDLE;
               rem_q       <= 8'd0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end

            default: begin
               state_q     <= IDLE;
               oe_q        <= 1'b0;
               we_q        <= 1'b0;
               msize_q     <= 4'd0;
               wr_ready_q  <= 1'b0;
               rd_valid_q  <= 1'b0;
               busy_q      <= 1'b0;
               cmd_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign cmd_ready_o          = cmd_ready_q;
   assign wr_ready_o           = wr_ready_q;
   assign rd_valid_o           = rd_valid_q;
   assign rd_data_o            = rd_data_q;
   assign Mout_oe_ram_o        = oe_q;
   assign Mout_we_ram_o        = we_q;
   assign Mout_addr_ram_o      = maddr_q;
   assign Mout_Wdata_ram_o     = mwdata_q;
   assign Mout_data_ram_size_o = msize_q;
   assign busy_o               = busy_q;
   assign err_timeout_o        = err_q;

endmodule
